mem_arbiter: RTL and testbench

- Shares the single-ported data memory between the instruction fetch unit (IFU, master 0, read-only) and the load/store unit (LSU, master 1, read/write).
- Sits between IFU/LSU and the memory slave and replaces their direct memory wiring.
- Serves one outstanding transaction at a time.
- Fixed priority to LSU, with an anti-starvation guard for IFU, plus a response-timeout watchdog.

---
 rtl/npc_bus_pkg.sv | 18 +
 rtl/mem_arbiter_if.sv | 54 +++++
 rtl/mem_arb_pick.sv | 45 ++++
 rtl/mem_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/npc_bus_pkg.sv
// Shared encodings for the NPC memory bus arbiter: FSM states, owner codes, reset values.
package npc_bus_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } arb_state_e;

  // Which master owns the outstanding transaction
  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  // Value loaded into the captured address on reset (sliced to AW by users)
  localparam logic [63:0] ADDR_RST = 64'd0;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between IFU/LSU, the arbiter and the memory slave.
// The "slave" modport is the arbiter's view (it serves the masters);
// the "master" modport is the surrounding system (IFU, LSU and memory).
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // IFU (master 0)
  logic            m0_req;
  logic [AW-1:0]   m0_addr;
  logic            m0_gnt;
  logic            m0_rvalid;
  logic [DW-1:0]   m0_rdata;
  // LSU (master 1)
  logic            m1_req;
  logic            m1_we;
  logic [AW-1:0]   m1_addr;
  logic [DW-1:0]   m1_wdata;
  logic [DW/8-1:0] m1_wmask;
  logic            m1_gnt;
  logic            m1_rvalid;
  logic [DW-1:0]   m1_rdata;
  // Memory slave
  logic            s_req;
  logic            s_we;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_wdata;
  logic [DW/8-1:0] s_wmask;
  logic            s_ready;
  logic            s_rvalid;
  logic [DW-1:0]   s_rdata;
  // Status
  logic            bus_err;

  modport slave (
    input  m0_req, m0_addr,
    input  m1_req, m1_we, m1_addr, m1_wdata, m1_wmask,
    input  s_ready, s_rvalid, s_rdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output s_req, s_we, s_addr, s_wdata, s_wmask,
    output bus_err
  );

  modport master (
    output m0_req, m0_addr,
    output m1_req, m1_we, m1_addr, m1_wdata, m1_wmask,
    output s_ready, s_rvalid, s_rdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  s_req, s_we, s_addr, s_wdata, s_wmask,
    input  bus_err
  );
endinterface

// File: rtl/mem_arb_pick.sv
// Combinational grant decision: LSU has priority, but once it has won
// MAX_LSU_STREAK times in a row while the IFU waited, the IFU goes next.
module mem_arb_pick
  import npc_bus_pkg::*;
#(
  parameter int MAX_LSU_STREAK = 4,
  parameter int SW             = 3
) (
  input  logic          en_i,
  input  logic          m0_req_i,
  input  logic          m1_req_i,
  input  logic [SW-1:0] streak_i,
  output logic          gnt0_o,
  output logic          gnt1_o
);

  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_LSU_STREAK);

  // Priority pick with the IFU anti-starvation override; the two grants are mutually exclusive
  always_comb begin
    gnt0_o = 1'b0;
    gnt1_o = 1'b0;
    if (en_i) begin
      case ({m0_req_i, m1_req_i})
        2'b01:   gnt1_o = 1'b1;
        2'b10:   gnt0_o = 1'b1;
        2'b11: begin
          if (streak_i == STREAK_MAX) begin
            gnt0_o = 1'b1;
          end else begin
            gnt1_o = 1'b1;
          end
        end
        default: begin
          gnt0_o = 1'b0;
          gnt1_o = 1'b0;
        end
      endcase
    end else begin
      gnt0_o = 1'b0;
      gnt1_o = 1'b0;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between IFU (read-only)
// and LSU (read/write), with a response watchdog and sticky bus error flag.
module mem_arbiter
  import npc_bus_pkg::*;
#(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int MAX_LSU_STREAK = 4,
  parameter int TIMEOUT        = 255
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  localparam int MW = DW / 8;
  localparam int SW = $clog2(MAX_LSU_STREAK + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_LSU_STREAK);
  localparam logic [TW-1:0] TIMEOUT_V  = TW'(TIMEOUT);

  arb_state_e    state_q,     state_d;
  logic          owner_q,     owner_d;
  logic          we_q,        we_d;
  logic [AW-1:0] addr_q,      addr_d;
  logic [DW-1:0] wdata_q,     wdata_d;
  logic [MW-1:0] wmask_q,     wmask_d;
  logic          s_req_q,     s_req_d;
  logic [SW-1:0] streak_q,    streak_d;
  logic [TW-1:0] wd_cnt_q,    wd_cnt_d;
  logic          m0_rvalid_q, m0_rvalid_d;
  logic          m1_rvalid_q, m1_rvalid_d;
  logic [DW-1:0] m0_rdata_q,  m0_rdata_d;
  logic [DW-1:0] m1_rdata_q,  m1_rdata_d;
  logic          bus_err_q,   bus_err_d;

  logic          arb_en_s;
  logic          gnt0_s;
  logic          gnt1_s;
  logic          complete_s;
  logic [DW-1:0] resp_s;
  logic [DW-1:0] resp_data_s;
  logic [TW-1:0] wd_next_s;

  // Grants are only offered while idle and never while reset is held
  assign arb_en_s  = (state_q == ST_IDLE) && !rst;
  assign wd_next_s = wd_cnt_q + TW'(1);

  mem_arb_pick #(
    .MAX_LSU_STREAK (MAX_LSU_STREAK),
    .SW             (SW)
  ) u_pick (
    .en_i     (arb_en_s),
    .m0_req_i (bus.m0_req),
    .m1_req_i (bus.m1_req),
    .streak_i (streak_q),
    .gnt0_o   (gnt0_s),
    .gnt1_o   (gnt1_s)
  );

  // Next-state: arbitration/capture in IDLE, slave handshake in REQ, response or watchdog in WAIT
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
    s_req_d     = 1'b0;
    streak_d    = streak_q;
    wd_cnt_d    = wd_cnt_q;
    m0_rvalid_d = 1'b0;
    m1_rvalid_d = 1'b0;
    m0_rdata_d  = m0_rdata_q;
    m1_rdata_d  = m1_rdata_q;
    bus_err_d   = bus_err_q;
    complete_s  = 1'b0;
    resp_s      = '0;
    resp_data_s = '0;

    case (state_q)
      ST_IDLE: begin
        if (gnt1_s) begin
          owner_d = OWN_LSU;
          we_d    = bus.m1_we;
          addr_d  = bus.m1_addr;
          wdata_d = bus.m1_wdata;
          wmask_d = bus.m1_wmask;
          s_req_d = 1'b1;
          state_d = ST_REQ;
          // Streak only counts LSU wins that kept a waiting IFU out
          if (bus.m0_req && (streak_q != STREAK_MAX)) begin
            streak_d = streak_q + SW'(1);
          end else begin
            streak_d = streak_q;
          end
        end else if (gnt0_s) begin
          owner_d  = OWN_IFU;
          we_d     = 1'b0;
          addr_d   = bus.m0_addr;
          wdata_d  = '0;
          wmask_d  = '0;
          s_req_d  = 1'b1;
          state_d  = ST_REQ;
          streak_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_REQ: begin
        if (bus.s_ready) begin
          if (bus.s_rvalid) begin
            complete_s = 1'b1;
            resp_s     = bus.s_rdata;
          end else begin
            state_d  = ST_WAIT;
            wd_cnt_d = '0;
          end
        end else begin
          s_req_d = 1'b1;
        end
      end

      ST_WAIT: begin
        if (bus.s_rvalid) begin
          complete_s = 1'b1;
          resp_s     = bus.s_rdata;
        end else if (wd_next_s == TIMEOUT_V) begin
          // Watchdog: finish the transaction with zero data and flag the error
          complete_s = 1'b1;
          resp_s     = '0;
          bus_err_d  = 1'b1;
        end else begin
          wd_cnt_d = wd_next_s;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (complete_s) begin
      state_d     = ST_IDLE;
      resp_data_s = we_q ? '0 : resp_s;
      if (owner_q == OWN_LSU) begin
        m1_rvalid_d = 1'b1;
        m1_rdata_d  = resp_data_s;
      end else begin
        m0_rvalid_d = 1'b1;
        m0_rdata_d  = resp_data_s;
      end
    end else begin
      resp_data_s = '0;
    end
  end

  // State, capture, watchdog and response registers; reset aborts any transaction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_IFU;
      we_q        <= 1'b0;
      addr_q      <= ADDR_RST[AW-1:0];
      wdata_q     <= '0;
      wmask_q     <= '0;
      s_req_q     <= 1'b0;
      streak_q    <= '0;
      wd_cnt_q    <= '0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      s_req_q     <= s_req_d;
      streak_q    <= streak_d;
      wd_cnt_q    <= wd_cnt_d;
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign bus.m0_gnt    = gnt0_s;
  assign bus.m1_gnt    = gnt1_s;
  assign bus.m0_rvalid = m0_rvalid_q;
  assign bus.m1_rvalid = m1_rvalid_q;
  assign bus.m0_rdata  = m0_rdata_q;
  assign bus.m1_rdata  = m1_rdata_q;
  assign bus.s_req     = s_req_q;
  assign bus.s_we      = we_q;
  assign bus.s_addr    = addr_q;
  assign bus.s_wdata   = wdata_q;
  assign bus.s_wmask   = wmask_q;
  assign bus.bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed stimulus pushes expected responses,
// a negedge monitor pops and compares whenever a master's rvalid fires.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(32), .DW(32)) ifc ();

  mem_arbiter #(
    .AW             (32),
    .DW             (32),
    .MAX_LSU_STREAK (4),
    .TIMEOUT        (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  typedef struct {
    logic        own;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Slave model knobs: ready delay, response mode (0 same cycle, 1 delayed, 2 never)
  int sl_rdy_dly = 0;
  int sl_mode    = 0;
  int sl_rv_dly  = 0;
  bit sl_late    = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: grant exclusivity and response scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (ifc.m0_gnt || ifc.m1_gnt)
        chk("gnt_overlap", 32'(ifc.m0_gnt & ifc.m1_gnt), 32'd0);
      if (ifc.m0_rvalid || ifc.m1_rvalid) begin
        if (sb.size() == 0) begin
          chk("unexpected_rvalid", 32'({ifc.m1_rvalid, ifc.m0_rvalid}), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rv_owner", 32'({ifc.m1_rvalid, ifc.m0_rvalid}), e.own ? 32'd2 : 32'd1);
          chk("rv_data", e.own ? ifc.m1_rdata : ifc.m0_rdata, e.data);
        end
      end
    end
  end

  // Memory slave model; read data is {addr[15:0], 16'h0413}
  initial begin : slave
    int          ph;
    int          cnt;
    logic [31:0] resp;
    ph = 0; cnt = 0; resp = 32'd0;
    ifc.s_ready = 1'b0; ifc.s_rvalid = 1'b0; ifc.s_rdata = 32'd0;
    forever begin
      @(posedge clk); #1;
      ifc.s_ready = 1'b0; ifc.s_rvalid = 1'b0; ifc.s_rdata = 32'd0;
      if (rst) begin
        ph = 0; cnt = 0;
      end else if (sl_late) begin
        ifc.s_rvalid = 1'b1; ifc.s_rdata = 32'hBAD0_0BAD; sl_late = 1'b0;
      end else if (ph == 0) begin
        if (ifc.s_req) begin
          if (cnt >= sl_rdy_dly) begin
            resp = {ifc.s_addr[15:0], 16'h0413};
            ifc.s_ready = 1'b1; cnt = 0;
            if (sl_mode == 0) begin
              ifc.s_rvalid = 1'b1; ifc.s_rdata = resp;
            end else if (sl_mode == 1) begin
              ph = 1;
            end
          end else begin
            cnt++;
          end
        end
      end else begin
        if (cnt >= sl_rv_dly) begin
          ifc.s_rvalid = 1'b1; ifc.s_rdata = resp; ph = 0; cnt = 0;
        end else begin
          cnt++;
        end
      end
    end
  end

  // Request from one master (called at posedge+1), wait for its grant, then drop req
  task automatic issue(input bit m, input bit we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] wm, input logic [31:0] exp);
    bit got;
    got = 1'b0;
    if (m) begin
      ifc.m1_req = 1'b1; ifc.m1_we = we; ifc.m1_addr = a; ifc.m1_wdata = wd; ifc.m1_wmask = wm;
    end else begin
      ifc.m0_req = 1'b1; ifc.m0_addr = a;
    end
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (m ? ifc.m1_gnt : ifc.m0_gnt) begin
        got = 1'b1;
        sb.push_back('{m, exp});
      end else begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    ifc.m0_req = 1'b0; ifc.m1_req = 1'b0;
    chk(m ? "m1_gnt_seen" : "m0_gnt_seen", 32'(got), 32'd1);
  endtask

  // Wait (bounded) until every expected response has been consumed
  task automatic drain(input string name);
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    chk(name, 32'(sb.size()), 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    bit exp_seq [6];
    int ng;
    int nreq;
    exp_seq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    rst = 1'b1;
    ifc.m0_req = 1'b0; ifc.m0_addr = 32'd0;
    ifc.m1_req = 1'b0; ifc.m1_we = 1'b0; ifc.m1_addr = 32'd0;
    ifc.m1_wdata = 32'd0; ifc.m1_wmask = 4'd0;
    #1;
    chk("rst_flags", 32'({ifc.s_req, ifc.s_we, ifc.m0_gnt, ifc.m1_gnt,
                          ifc.m0_rvalid, ifc.m1_rvalid, ifc.bus_err}), 32'd0);
    chk("rst_s_addr", ifc.s_addr, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;

    // 1) Single IFU read, immediate slave: gnt c0, s_req c1, rvalid c2
    @(posedge clk); #1;
    ifc.m0_req = 1'b1; ifc.m0_addr = 32'h8000_0000;
    @(negedge clk);
    chk("t1_m0_gnt", 32'({ifc.m0_gnt, ifc.m1_gnt}), 32'd2);
    sb.push_back('{1'b0, 32'h0000_0413});
    @(posedge clk); #1; ifc.m0_req = 1'b0;
    @(negedge clk);
    chk("t1_s_req", 32'({ifc.s_req, ifc.s_we}), 32'd2);
    chk("t1_s_addr", ifc.s_addr, 32'h8000_0000);
    @(negedge clk);
    chk("t1_m0_rvalid", 32'(ifc.m0_rvalid), 32'd1);
    @(negedge clk);
    chk("t1_idle", 32'({ifc.m0_rvalid, ifc.s_req}), 32'd0);

    // 2) LSU write, ready after 3 cycles, response 2 cycles later; s_* held stable
    sl_rdy_dly = 3; sl_mode = 1; sl_rv_dly = 2;
    @(posedge clk); #1;
    ifc.m1_req = 1'b1; ifc.m1_we = 1'b1; ifc.m1_addr = 32'h8000_1000;
    ifc.m1_wdata = 32'hDEAD_BEEF; ifc.m1_wmask = 4'b0011;
    @(negedge clk);
    chk("t2_m1_gnt", 32'({ifc.m0_gnt, ifc.m1_gnt}), 32'd1);
    sb.push_back('{1'b1, 32'h0000_0000});
    @(posedge clk); #1;
    ifc.m1_req = 1'b0; ifc.m1_addr = 32'd0; ifc.m1_wdata = 32'd0; ifc.m1_wmask = 4'd0; ifc.m1_we = 1'b0;
    nreq = 0;
    for (int i = 0; i < 20 && !ifc.m1_rvalid; i++) begin
      @(negedge clk);
      if (ifc.s_req) begin
        nreq++;
        chk("t2_s_addr", ifc.s_addr, 32'h8000_1000);
        chk("t2_s_wdata", ifc.s_wdata, 32'hDEAD_BEEF);
        chk("t2_s_we_mask", 32'({ifc.s_we, ifc.s_wmask}), 32'h13);
      end
    end
    chk("t2_s_req_cycles", 32'(nreq), 32'd4);
    drain("t2_drain");

    // 3) Contention: both held, expect L L L L I L
    sl_rdy_dly = 0; sl_mode = 0;
    @(posedge clk); #1;
    ifc.m0_req = 1'b1; ifc.m0_addr = 32'h8000_0040;
    ifc.m1_req = 1'b1; ifc.m1_we = 1'b0; ifc.m1_addr = 32'h8000_2000;
    ng = 0;
    for (int i = 0; i < 60 && ng < 6; i++) begin
      @(negedge clk);
      if (ifc.m0_gnt || ifc.m1_gnt) begin
        chk("cont_owner", 32'(ifc.m1_gnt), 32'(exp_seq[ng]));
        if (ifc.m1_gnt) sb.push_back('{1'b1, 32'h2000_0413});
        else            sb.push_back('{1'b0, 32'h0040_0413});
        ng++;
      end
      if (ng < 6) begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    ifc.m0_req = 1'b0; ifc.m1_req = 1'b0;
    chk("cont_grants", 32'(ng), 32'd6);
    drain("cont_drain");

    // 4) Back-to-back: IFU re-requests in its rvalid cycle and is granted there
    @(posedge clk); #1;
    ifc.m0_req = 1'b1; ifc.m0_addr = 32'h8000_0080;
    @(negedge clk);
    chk("b2b_gnt_a", 32'(ifc.m0_gnt), 32'd1);
    sb.push_back('{1'b0, 32'h0080_0413});
    @(posedge clk); #1; ifc.m0_req = 1'b0;
    @(posedge clk); #1; ifc.m0_req = 1'b1; ifc.m0_addr = 32'h8000_00C0;
    @(negedge clk);
    chk("b2b_rv_and_gnt", 32'({ifc.m0_rvalid, ifc.m0_gnt}), 32'd3);
    sb.push_back('{1'b0, 32'h00C0_0413});
    @(posedge clk); #1; ifc.m0_req = 1'b0;
    drain("b2b_drain");

    // 5) Timeout: slave never answers; 8 WAIT cycles then rvalid with 0 and bus_err
    sl_mode = 2;
    @(posedge clk); #1;
    ifc.m1_req = 1'b1; ifc.m1_we = 1'b0; ifc.m1_addr = 32'h8000_3000;
    @(negedge clk);
    chk("to_gnt", 32'(ifc.m1_gnt), 32'd1);
    sb.push_back('{1'b1, 32'h0000_0000});
    @(posedge clk); #1; ifc.m1_req = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      chk("to_quiet", 32'({ifc.bus_err, ifc.m1_rvalid}), 32'd0);
    end
    @(negedge clk);
    chk("to_fire", 32'({ifc.bus_err, ifc.m1_rvalid}), 32'd3);
    sl_late = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("late_rv_ignored", 32'({ifc.bus_err, ifc.m0_rvalid, ifc.m1_rvalid}), 32'd4);
    end
    chk("to_drain", 32'(sb.size()), 32'd0);

    // 6) Reset mid-WAIT: outputs clear at once, no response, next request served
    @(posedge clk); #1;
    ifc.m0_req = 1'b1; ifc.m0_addr = 32'h8000_5000;
    @(negedge clk);
    chk("rw_gnt", 32'(ifc.m0_gnt), 32'd1);
    @(posedge clk); #1; ifc.m0_req = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rw_in_wait", 32'({ifc.s_req, ifc.bus_err}), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rw_flags", 32'({ifc.s_req, ifc.m0_gnt, ifc.m1_gnt,
                         ifc.m0_rvalid, ifc.m1_rvalid, ifc.bus_err}), 32'd0);
    chk("rw_m0_rdata", ifc.m0_rdata, 32'd0);
    chk("rw_s_addr", ifc.s_addr, 32'd0);
    @(posedge clk);
    @(negedge clk); rst = 1'b0; sl_mode = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("rw_no_rvalid", 32'({ifc.m0_rvalid, ifc.m1_rvalid}), 32'd0);
    end
    @(posedge clk); #1;
    issue(1'b1, 1'b0, 32'h8000_4000, 32'd0, 4'd0, 32'h4000_0413);
    drain("rw_after_drain");
    chk("rw_bus_err_clear", 32'(ifc.bus_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
